// File: rtl/issue_bank_age_pkg.sv
// rtl/issue_bank_age_pkg.sv - shared types and ROB ordering helper for the issue bank
package issue_bank_age_pkg;

    localparam int ROB_IDX_MAX   = 16;
    localparam int DEF_ROB_WIDTH = 6;
    localparam int DEF_PREG      = 7;
    localparam int DEF_DATA      = 64;
    localparam int DEF_SRC       = 2;

    typedef struct packed {
        logic                     dir;
        logic [DEF_ROB_WIDTH-1:0] idx;
    } rob_idx_t;

    typedef struct packed {
        logic [DEF_SRC-1:0]          src_v;
        logic [DEF_SRC*DEF_PREG-1:0] src_p;
        logic                        we;
        logic [DEF_PREG-1:0]         rd;
        rob_idx_t                    rob_idx;
        logic [DEF_DATA-1:0]         data;
    } issue_entry_t;

    // True when a is strictly older than b; idx fields are zero-extended by the caller.
    function automatic logic rob_older(input logic dir_a, input logic [ROB_IDX_MAX-1:0] idx_a,
                                       input logic dir_b, input logic [ROB_IDX_MAX-1:0] idx_b);
        return (dir_a ^ dir_b) ^ (idx_a < idx_b);
    endfunction

endpackage

// File: rtl/issue_bank_age_age_matrix.sv
// rtl/issue_bank_age_age_matrix.sv - age matrix tracking enqueue order and picking the oldest ready entry
module issue_bank_age_age_matrix
    import issue_bank_age_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_en,
    input  logic [DEPTH-1:0] enq_slot,
    input  logic [DEPTH-1:0] valid,
    input  logic [DEPTH-1:0] ready,
    output logic [DEPTH-1:0] sel
);

    // old_q[i][j] = 1: entry i was enqueued after entry j (i is younger)
    logic [DEPTH-1:0] old_q [DEPTH];

    // New entry is younger than every resident entry; nobody is younger than it yet.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) old_q[i] <= '0;
        end else if (enq_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (enq_slot[i]) old_q[i] <= valid & ~enq_slot;
                else             old_q[i] <= old_q[i] & ~enq_slot;
            end
        end
    end

    // Pick the ready entry that is not younger than any other ready entry.
    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) sel[i] = ready[i] & ~|(ready & old_q[i]);
    end

endmodule

// File: rtl/issue_bank_age.sv
// rtl/issue_bank_age.sv - issue queue bank with wakeup, oldest-ready select and redirect flush
module issue_bank_age
    import issue_bank_age_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int SRC_NUM    = 2,
    parameter int WB_SIZE    = 4,
    parameter int PREG_WIDTH = 7,
    parameter int ROB_WIDTH  = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enq_valid,
    output logic                          enq_ready,
    input  logic [SRC_NUM-1:0]            enq_src_v,
    input  logic [SRC_NUM*PREG_WIDTH-1:0] enq_src_p,
    input  logic                          enq_we,
    input  logic [PREG_WIDTH-1:0]         enq_rd,
    input  logic [ROB_WIDTH:0]            enq_rob_idx,
    input  logic [DATA_WIDTH-1:0]         enq_data,
    input  logic [WB_SIZE-1:0]            wb_valid,
    input  logic [WB_SIZE*PREG_WIDTH-1:0] wb_rd,
    input  logic                          redirect,
    input  logic [ROB_WIDTH:0]            redirect_idx,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [SRC_NUM*PREG_WIDTH-1:0] iss_src_p,
    output logic                          iss_we,
    output logic [PREG_WIDTH-1:0]         iss_rd,
    output logic [ROB_WIDTH:0]            iss_rob_idx,
    output logic [DATA_WIDTH-1:0]         iss_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]              valid_q;
    logic [SRC_NUM-1:0]            src_v_q  [DEPTH];
    logic [SRC_NUM*PREG_WIDTH-1:0] src_p_q  [DEPTH];
    logic                          we_q     [DEPTH];
    logic [PREG_WIDTH-1:0]         rd_q     [DEPTH];
    logic [ROB_WIDTH:0]            rob_q    [DEPTH];
    logic [DATA_WIDTH-1:0]         data_q   [DEPTH];

    logic [SRC_NUM-1:0] src_v_wk [DEPTH];
    logic [SRC_NUM-1:0] enq_src_v_wk;
    logic [DEPTH-1:0]   ready, keep, sel, free_oh;
    logic               enq_fire, iss_fire, found;
    logic [ROB_IDX_MAX-1:0] idx_e, idx_r;

    function automatic logic wake_hit(input logic [PREG_WIDTH-1:0] tag);
        logic hit = 1'b0;
        for (int j = 0; j < WB_SIZE; j++)
            hit |= wb_valid[j] & (wb_rd[j*PREG_WIDTH +: PREG_WIDTH] == tag);
        return hit;
    endfunction

    assign enq_ready = ~&valid_q;
    assign enq_fire  = enq_valid & enq_ready & ~redirect;
    assign iss_valid = |ready & ~redirect;
    assign iss_fire  = iss_valid & iss_ready;

    // Lowest-index free slot for the next enqueue.
    always_comb begin
        free_oh = '0;
        found   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !found) begin
                free_oh[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    // Wakeup (resident and enqueue bypass), readiness and redirect survival per entry.
    always_comb begin
        idx_r = '0;
        idx_r[ROB_WIDTH-1:0] = redirect_idx[ROB_WIDTH-1:0];
        for (int k = 0; k < SRC_NUM; k++)
            enq_src_v_wk[k] = enq_src_v[k] | wake_hit(enq_src_p[k*PREG_WIDTH +: PREG_WIDTH]);
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < SRC_NUM; k++)
                src_v_wk[i][k] = src_v_q[i][k] | wake_hit(src_p_q[i][k*PREG_WIDTH +: PREG_WIDTH]);
            ready[i] = valid_q[i] & (&src_v_q[i]);
            idx_e = '0;
            idx_e[ROB_WIDTH-1:0] = rob_q[i][ROB_WIDTH-1:0];
            keep[i] = rob_older(rob_q[i][ROB_WIDTH], idx_e, redirect_idx[ROB_WIDTH], idx_r);
        end
    end

    issue_bank_age_age_matrix #(.DEPTH(DEPTH)) u_age (
        .clk      (clk),
        .rst      (rst),
        .enq_en   (enq_fire),
        .enq_slot (free_oh),
        .valid    (valid_q),
        .ready    (ready),
        .sel      (sel)
    );

    // Issue payload mux driven by the one-hot oldest-ready select.
    always_comb begin
        iss_src_p   = '0;
        iss_we      = 1'b0;
        iss_rd      = '0;
        iss_rob_idx = '0;
        iss_data    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                iss_src_p   |= src_p_q[i];
                iss_we      |= we_q[i];
                iss_rd      |= rd_q[i];
                iss_rob_idx |= rob_q[i];
                iss_data    |= data_q[i];
            end
        end
    end

    // Occupancy from registered valid bits only.
    always_comb begin
        count = '0;
        for (int i = 0; i < DEPTH; i++) count += CW'(valid_q[i]);
    end

    // Entry state: enqueue write, wakeup accumulation, issue free and redirect flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) src_v_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (redirect) begin
                    valid_q[i] <= valid_q[i] & keep[i];
                    src_v_q[i] <= src_v_wk[i];
                end else if (enq_fire && free_oh[i]) begin
                    valid_q[i] <= 1'b1;
                    src_v_q[i] <= enq_src_v_wk;
                    src_p_q[i] <= enq_src_p;
                    we_q[i]    <= enq_we;
                    rd_q[i]    <= enq_rd;
                    rob_q[i]   <= enq_rob_idx;
                    data_q[i]  <= enq_data;
                end else begin
                    if (iss_fire && sel[i]) valid_q[i] <= 1'b0;
                    src_v_q[i] <= src_v_wk[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_bank_age.sv
// tb/tb_issue_bank_age.sv - scoreboard bench for issue_bank_age
module tb_issue_bank_age;
    import issue_bank_age_pkg::*;

    localparam logic [63:0] DATA_TAG = 64'hDA7A_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, enq_ready, enq_we;
    logic [1:0]  enq_src_v;
    logic [13:0] enq_src_p;
    logic [6:0]  enq_rd, enq_rob_idx;
    logic [63:0] enq_data;
    logic [3:0]  wb_valid;
    logic [27:0] wb_rd;
    logic        redirect;
    logic [6:0]  redirect_idx;
    logic        iss_valid, iss_ready, iss_we;
    logic [13:0] iss_src_p;
    logic [6:0]  iss_rd, iss_rob_idx;
    logic [63:0] iss_data;
    logic [4:0]  count;

    int vectors = 0;
    int errs    = 0;
    logic [6:0] exp_q [$];

    issue_bank_age dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_src_v(enq_src_v), .enq_src_p(enq_src_p),
        .enq_we(enq_we), .enq_rd(enq_rd), .enq_rob_idx(enq_rob_idx), .enq_data(enq_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .redirect(redirect), .redirect_idx(redirect_idx),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_src_p(iss_src_p), .iss_we(iss_we),
        .iss_rd(iss_rd), .iss_rob_idx(iss_rob_idx), .iss_data(iss_data), .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish (act=timeout req=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: act=%0h req=%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted issue is matched against the next expected robIdx.
    always @(negedge clk) begin
        if (!rst && iss_valid && iss_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL issue_unexpected: act=%0h req=none", iss_rob_idx);
            end else begin
                logic [6:0] e;
                e = exp_q.pop_front();
                if (iss_rob_idx !== e || iss_data !== (DATA_TAG | 64'(e)) || iss_rd !== e) begin
                    errs++;
                    $display("FAIL issue_order: act rob=%0h data=%0h req rob=%0h data=%0h",
                             iss_rob_idx, iss_data, e, DATA_TAG | 64'(e));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [6:0] rob, input logic [1:0] sv,
                       input logic [6:0] p1, input logic [6:0] p0);
        enq_valid   = 1'b1;
        enq_rob_idx = rob;
        enq_rd      = rob;
        enq_we      = 1'b1;
        enq_src_v   = sv;
        enq_src_p   = {p1, p0};
        enq_data    = DATA_TAG | 64'(rob);
        tick();
        enq_valid   = 1'b0;
        enq_src_v   = 2'b00;
        enq_src_p   = '0;
    endtask

    initial begin
        rst = 1'b1; enq_valid = 1'b0; enq_we = 1'b0; enq_src_v = '0; enq_src_p = '0;
        enq_rd = '0; enq_rob_idx = '0; enq_data = '0; wb_valid = '0; wb_rd = '0;
        redirect = 1'b0; redirect_idx = '0; iss_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        check("reset_enq_ready", 64'(enq_ready), 64'd1);
        check("reset_iss_valid", 64'(iss_valid), 64'd0);
        check("reset_count", 64'(count), 64'd0);

        // single ready uop
        enq(7'h01, 2'b11, 7'd0, 7'd0);
        check("t1_iss_valid", 64'(iss_valid), 64'd1);
        check("t1_rob", 64'(iss_rob_idx), 64'h01);
        check("t1_count", 64'(count), 64'd1);
        exp_q.push_back(7'h01);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t1_count_after", 64'(count), 64'd0);

        // rob5 waits on p9, rob3 ready; wakeup lets rob5 issue the following cycle
        enq(7'h05, 2'b01, 7'd9, 7'd0);
        enq(7'h03, 2'b11, 7'd0, 7'd0);
        check("t2_first_pick", 64'(iss_rob_idx), 64'h03);
        wb_valid = 4'b0001; wb_rd = {7'd0, 7'd0, 7'd0, 7'd9};
        exp_q.push_back(7'h03); exp_q.push_back(7'h05);
        iss_ready = 1'b1; tick(); wb_valid = '0; tick(); iss_ready = 1'b0;
        check("t2_count", 64'(count), 64'd0);

        // same-cycle enqueue bypass on both sources
        wb_valid = 4'b0001; wb_rd = {7'd0, 7'd0, 7'd0, 7'd12};
        enq(7'h0A, 2'b00, 7'd12, 7'd12);
        wb_valid = '0;
        check("t3_iss_valid", 64'(iss_valid), 64'd1);
        check("t3_rob", 64'(iss_rob_idx), 64'h0A);
        exp_q.push_back(7'h0A);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t3_count", 64'(count), 64'd0);

        // fill, hold without ready, then drain in age order
        for (int i = 0; i < 16; i++) enq(7'(16 + i), 2'b11, 7'd0, 7'd0);
        check("t4_full_enq_ready", 64'(enq_ready), 64'd0);
        check("t4_full_count", 64'(count), 64'd16);
        for (int c = 0; c < 3; c++) begin
            check("t4_hold_rob", 64'(iss_rob_idx), 64'd16);
            check("t4_hold_count", 64'(count), 64'd16);
            tick();
        end
        exp_q.push_back(7'd16);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t4_count_15", 64'(count), 64'd15);
        check("t4_enq_ready", 64'(enq_ready), 64'd1);
        for (int i = 1; i < 16; i++) exp_q.push_back(7'(16 + i));
        iss_ready = 1'b1; repeat (15) tick(); iss_ready = 1'b0;
        check("t4_drained", 64'(count), 64'd0);

        // redirect flush at {0,7}; simultaneous enqueue dropped
        enq(7'h03, 2'b11, 7'd0, 7'd0);
        enq(7'h07, 2'b11, 7'd0, 7'd0);
        enq(7'h41, 2'b11, 7'd0, 7'd0);
        redirect = 1'b1; redirect_idx = 7'h07;
        enq_valid = 1'b1; enq_rob_idx = 7'h09; enq_rd = 7'h09; enq_src_v = 2'b11;
        enq_data = DATA_TAG | 64'h09;
        iss_ready = 1'b1;
        #1;
        check("t5_iss_valid_redirect", 64'(iss_valid), 64'd0);
        tick();
        redirect = 1'b0; enq_valid = 1'b0; iss_ready = 1'b0;
        check("t5_count", 64'(count), 64'd1);
        check("t5_survivor", 64'(iss_rob_idx), 64'h03);
        exp_q.push_back(7'h03);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t5_count_after", 64'(count), 64'd0);

        // age beats slot position, and ordering across the dir wrap
        enq(7'h3A, 2'b01, 7'd50, 7'd0);
        enq(7'h3B, 2'b11, 7'd0, 7'd0);
        enq(7'h3C, 2'b11, 7'd0, 7'd0);
        exp_q.push_back(7'h3B);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        enq(7'h42, 2'b11, 7'd0, 7'd0);
        check("t6_pick_older_high_slot", 64'(iss_rob_idx), 64'h3C);
        exp_q.push_back(7'h3C); exp_q.push_back(7'h42);
        iss_ready = 1'b1; tick(); tick(); iss_ready = 1'b0;
        check("t6_waiting_not_valid", 64'(iss_valid), 64'd0);
        wb_valid = 4'b0010; wb_rd = {7'd0, 7'd0, 7'd50, 7'd0};
        tick();
        wb_valid = '0;
        exp_q.push_back(7'h3A);
        iss_ready = 1'b1; tick(); iss_ready = 1'b0;
        check("t6_count", 64'(count), 64'd0);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
